// File: rtl/cnn_load_pkg.sv
// Shared definitions for the accelerator parameter loader: load phases,
// layer codes and the bit offsets of each field on the 784-bit image bus.
package cnn_load_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      K1   = 3'd1,
      K2   = 3'd2,
      KFC  = 3'd3,
      O1   = 3'd4,
      O2   = 3'd5,
      OFC  = 3'd6,
      DONE = 3'd7
   } phase_e;

   localparam logic [1:0] LAYER_NONE = 2'd0;
   localparam logic [1:0] LAYER_C1   = 2'd1;
   localparam logic [1:0] LAYER_C2   = 2'd2;
   localparam logic [1:0] LAYER_FC   = 2'd3;

   localparam int IMG_W    = 784;
   localparam int KERN_LSB = 0;
   localparam int NUM_LSB  = 84;
   localparam int A18_LSB  = 112;
   localparam int A5_LSB   = 140;
   localparam int A10_LSB  = 168;
   localparam int A60_LSB  = 196;
   localparam int A960_LSB = 224;

   // Payload widths that survive onto the bus; remaining payload bits are dropped.
   localparam int KERN_W = 25;
   localparam int O1_W   = 7;
   localparam int O2_W   = 9;
   localparam int OFC_W  = 8;

   function automatic logic is_load(input phase_e p);
      return (p != IDLE) && (p != DONE);
   endfunction

endpackage

// File: rtl/nested_counter.sv
// Two-level address counter with run-time limits; the inner count wraps into
// the outer count, and both clear together after the final beat.
module nested_counter #(
   parameter int INNER_MAX = 960,
   parameter int OUTER_MAX = 60,
   parameter int IW = $clog2(INNER_MAX + 1),
   parameter int OW = $clog2(OUTER_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [IW-1:0] inner_lim,
   input  logic [OW-1:0] outer_lim,
   output logic [IW-1:0] inner,
   output logic [OW-1:0] outer,
   output logic          last
);

   logic inner_end;
   logic outer_end;

   assign inner_end = (inner == inner_lim - 1'b1);
   assign outer_end = (outer == outer_lim - 1'b1);
   assign last      = inner_end && outer_end;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         inner <= '0;
         outer <= '0;
      end else if (inc) begin
         if (inner_end) begin
            inner <= '0;
            outer <= outer_end ? '0 : outer + 1'b1;
         end else begin
            inner <= inner + 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_stream_loader.sv
// Streams host payload words onto the accelerator image bus in a fixed
// kernel-then-offset schedule, generating the address fields for each write.
module param_stream_loader
   import cnn_load_pkg::*;
#(
   parameter int DATA_W = 25,
   parameter int C1_OUT = 18,
   parameter int C1_K   = 5,
   parameter int C2_OUT = 60,
   parameter int FC_OUT = 10,
   parameter int FC_IN  = 960
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [IMG_W-1:0]  image,
   output logic [1:0]        kernel_layer,
   output logic [1:0]        offset_layer,
   output logic              busy,
   output logic              load_done,
   output logic [2:0]        phase
);

   localparam int A18_W  = $clog2(C1_OUT);
   localparam int A5_W   = $clog2(C1_K);
   localparam int A60_W  = $clog2(C2_OUT);
   localparam int A10_W  = $clog2(FC_OUT);
   localparam int A960_W = $clog2(FC_IN);
   localparam int CIW    = $clog2(FC_IN + 1);
   localparam int COW    = $clog2(C2_OUT + 1);

   phase_e           state;
   phase_e           state_nxt;
   logic             accept;
   logic             cnt_clr;
   logic             cnt_last;
   logic [CIW-1:0]   inner_lim;
   logic [COW-1:0]   outer_lim;
   logic [CIW-1:0]   inner;
   logic [COW-1:0]   outer;
   logic [IMG_W-1:0] image_p1;
   logic [1:0]       kernel_layer_p1;
   logic [1:0]       offset_layer_p1;
   logic             load_done_p1;

   function automatic logic [IMG_W-1:0] pack_image(input phase_e p, input logic [DATA_W-1:0] d,
                                                   input logic [CIW-1:0] i, input logic [COW-1:0] o);
      logic [IMG_W-1:0] img;
      img = '0;
      case (p)
         K1: begin
            img[KERN_LSB +: KERN_W] = d[KERN_W-1:0];
            img[A5_LSB +: A5_W]     = i[A5_W-1:0];
            img[A18_LSB +: A18_W]   = o[A18_W-1:0];
         end
         K2: begin
            img[KERN_LSB +: KERN_W] = d[KERN_W-1:0];
            img[A18_LSB +: A18_W]   = i[A18_W-1:0];
            img[A60_LSB +: A60_W]   = o[A60_W-1:0];
         end
         KFC: begin
            img[NUM_LSB]            = d[0];
            img[A960_LSB +: A960_W] = i[A960_W-1:0];
            img[A10_LSB +: A10_W]   = o[A10_W-1:0];
         end
         O1: begin
            img[NUM_LSB +: O1_W]  = d[O1_W-1:0];
            img[A18_LSB +: A18_W] = i[A18_W-1:0];
         end
         O2: begin
            img[NUM_LSB +: O2_W]  = d[O2_W-1:0];
            img[A60_LSB +: A60_W] = i[A60_W-1:0];
         end
         OFC: begin
            img[NUM_LSB +: OFC_W] = d[OFC_W-1:0];
            img[A10_LSB +: A10_W] = i[A10_W-1:0];
         end
         default: ;
      endcase
      return img;
   endfunction

   function automatic logic [1:0] kernel_code(input phase_e p);
      case (p)
         K1:      return LAYER_C1;
         K2:      return LAYER_C2;
         KFC:     return LAYER_FC;
         default: return LAYER_NONE;
      endcase
   endfunction

   function automatic logic [1:0] offset_code(input phase_e p);
      case (p)
         O1:      return LAYER_C1;
         O2:      return LAYER_C2;
         OFC:     return LAYER_FC;
         default: return LAYER_NONE;
      endcase
   endfunction

   nested_counter #(
      .INNER_MAX (FC_IN),
      .OUTER_MAX (C2_OUT)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .inc       (accept),
      .inner_lim (inner_lim),
      .outer_lim (outer_lim),
      .inner     (inner),
      .outer     (outer),
      .last      (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Counter limits are re-ranged per phase so one counter serves every pass.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      in_ready  = is_load(state);
      busy      = is_load(state);
      inner_lim = CIW'(1);
      outer_lim = COW'(1);
      accept    = in_valid && is_load(state);
      case (state)
         IDLE, DONE: if (start) begin
            state_nxt = K1;
            cnt_clr   = 1'b1;
         end
         K1: begin
            inner_lim = CIW'(C1_K);
            outer_lim = COW'(C1_OUT);
            if (accept && cnt_last) state_nxt = K2;
         end
         K2: begin
            inner_lim = CIW'(C1_OUT);
            outer_lim = COW'(C2_OUT);
            if (accept && cnt_last) state_nxt = KFC;
         end
         KFC: begin
            inner_lim = CIW'(FC_IN);
            outer_lim = COW'(FC_OUT);
            if (accept && cnt_last) state_nxt = O1;
         end
         O1: begin
            inner_lim = CIW'(C1_OUT);
            if (accept && cnt_last) state_nxt = O2;
         end
         O2: begin
            inner_lim = CIW'(C2_OUT);
            if (accept && cnt_last) state_nxt = OFC;
         end
         OFC: begin
            inner_lim = CIW'(FC_OUT);
            if (accept && cnt_last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p1: one write per accepted beat; the bus is idle (all-zero) otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         image_p1        <= '0;
         kernel_layer_p1 <= LAYER_NONE;
         offset_layer_p1 <= LAYER_NONE;
      end else if (accept) begin
         image_p1        <= pack_image(state, in_data, inner, outer);
         kernel_layer_p1 <= kernel_code(state);
         offset_layer_p1 <= offset_code(state);
      end else begin
         image_p1        <= '0;
         kernel_layer_p1 <= LAYER_NONE;
         offset_layer_p1 <= LAYER_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                         load_done_p1 <= 1'b0;
      else if (!is_load(state) && start)               load_done_p1 <= 1'b0;
      else if (state == OFC && accept && cnt_last)     load_done_p1 <= 1'b1;
   end

   assign image        = image_p1;
   assign kernel_layer = kernel_layer_p1;
   assign offset_layer = offset_layer_p1;
   assign load_done    = load_done_p1;
   assign phase        = state;

endmodule
